// File: rtl/sram_mem_ctrl_if.sv
// Purpose: MEM-stage request/response bundle between the pipeline and the SRAM controller.
// Signals:
//   wr_en, rd_en  store / load request (held stable by the pipeline freeze while ready=0)
//   address       32-bit byte address (bits [1:0] ignored by the controller)
//   wdata         32-bit store data
//   rdata         32-bit load data, valid in the DONE cycle and held afterwards
//   ready         combinational; low while an access is in flight
// Modports: master = pipeline side, slave = controller side.
interface sram_mem_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Purpose: multi-cycle controller between the MEM stage and a 16-bit asynchronous SRAM.
//   Each 32-bit word access becomes two half-word SRAM accesses, low half first.
//   ready stays low while an access is in flight so the pipeline freezes.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   bus (slave)       wr_en, rd_en, address, wdata in; rdata, ready out
//   SRAM_DQ           16-bit bidirectional SRAM data bus
//   SRAM_ADDR         half-word address {word_addr, half}
//   SRAM_WE_N/OE_N/CE_N  active-low strobes, all registered
//   SRAM_UB_N/LB_N    byte enables, tied low (always full half-word)
module sram_mem_ctrl #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_mem_ctrl_if.slave    bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int unsigned WADDR_W  = ADDR_W - 1;
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic                 op_wr;
    logic [WADDR_W-1:0]   waddr;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic                 dq_oe;
    logic [15:0]          dq_out;

    logic                 req_c;
    logic [WADDR_W-1:0]   waddr_c;
    logic                 last_c;
    logic                 near_last_c;

    // Request decode and SRAM word address (modulo wrap, no range error).
    assign req_c       = bus.rd_en | bus.wr_en;
    assign waddr_c     = WADDR_W'((bus.address - 32'(BASE_ADDR)) >> 2);
    assign last_c      = (cnt == LAST_CNT);
    assign near_last_c = ((cnt + 4'd1) == LAST_CNT);

    // ready is combinational so an idle pipeline never stalls.
    assign bus.ready = ~req_c | (state == DONE);
    assign bus.rdata = rdata_q;

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Access FSM; strobes are set one edge ahead so they are glitch-free registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            waddr     <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            dq_oe     <= 1'b0;
            dq_out    <= 16'd0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c) begin
                        // Write wins when both requests are raised.
                        state     <= LO;
                        cnt       <= 4'd0;
                        op_wr     <= bus.wr_en;
                        waddr     <= waddr_c;
                        wdata_q   <= bus.wdata;
                        SRAM_ADDR <= {waddr_c, 1'b0};
                        SRAM_CE_N <= 1'b0;
                        SRAM_WE_N <= ~bus.wr_en;
                        SRAM_OE_N <= bus.wr_en;
                        dq_oe     <= bus.wr_en;
                        dq_out    <= bus.wdata[15:0];
                    end
                end

                LO: begin
                    if (last_c) begin
                        state     <= HI;
                        cnt       <= 4'd0;
                        SRAM_ADDR <= {waddr, 1'b1};
                        SRAM_WE_N <= ~op_wr;
                        SRAM_OE_N <= op_wr;
                        dq_out    <= wdata_q[31:16];
                        if (!op_wr) begin
                            rdata_q[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        // Raise WE_N for the final phase cycle: commits with address/data stable.
                        if (op_wr && near_last_c) begin
                            SRAM_WE_N <= 1'b1;
                        end
                    end
                end

                HI: begin
                    if (last_c) begin
                        state     <= DONE;
                        cnt       <= 4'd0;
                        SRAM_CE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!op_wr) begin
                            rdata_q[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (op_wr && near_last_c) begin
                            SRAM_WE_N <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Pipeline advances on this edge; a new request is taken from IDLE.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Purpose: directed self-checking bench for sram_mem_ctrl with a behavioural async SRAM.
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        model_en;
    logic [15:0] sram [2**18];

    int n_cmp;
    int n_err;

    sram_mem_ctrl_if bus ();

    sram_mem_ctrl #(
        .ADDR_W      (18),
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM: drives DQ when selected and output-enabled, latches on WE_N rising.
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR] : 16'hzzzz;

    always @(posedge SRAM_WE_N) begin
        if (model_en && !SRAM_CE_N) begin
            sram[SRAM_ADDR] <= SRAM_DQ;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One word access, checked cycle by cycle (cycle 0 = request seen in IDLE, cycle 5 = DONE).
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [17:0] exp_lo,
                          input logic scramble);
        @(posedge clk);
        #2;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.address = addr;
        bus.wdata   = wd;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #2;
                if (scramble && k == 2) begin
                    bus.address = ~addr;
                    bus.wdata   = ~wd;
                end
                #1;
            end
            chk({tag, ":ready"}, 32'(bus.ready), 32'(k == 5));
            chk({tag, ":ce_n"}, 32'(SRAM_CE_N), 32'(!(k >= 1 && k <= 4)));
            chk({tag, ":we_n"}, 32'(SRAM_WE_N), 32'(!(wr && (k == 1 || k == 3))));
            chk({tag, ":oe_n"}, 32'(SRAM_OE_N), 32'(!(!wr && k >= 1 && k <= 4)));
            if (k >= 1 && k <= 4) begin
                chk({tag, ":sram_addr"}, 32'(SRAM_ADDR), 32'(exp_lo) + 32'(k >= 3));
            end
            if (k == 5) begin
                chk({tag, ":rdata"}, bus.rdata, exp_rd);
            end
        end
    endtask

    task automatic idle(input string tag, input int n, input logic [31:0] exp_rd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
            #1;
            chk({tag, ":ready"}, 32'(bus.ready), 32'd1);
            chk({tag, ":ce_n"}, 32'(SRAM_CE_N), 32'd1);
            chk({tag, ":we_n"}, 32'(SRAM_WE_N), 32'd1);
            chk({tag, ":oe_n"}, 32'(SRAM_OE_N), 32'd1);
            chk({tag, ":rdata"}, bus.rdata, exp_rd);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        model_en    = 1'b0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.address = 32'd0;
        bus.wdata   = 32'd0;

        // Reset
        @(posedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        model_en = 1'b1;
        #1;
        chk("rst:ready", 32'(bus.ready), 32'd1);
        chk("rst:ce_n", 32'(SRAM_CE_N), 32'd1);
        chk("rst:we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst:oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("rst:rdata", bus.rdata, 32'd0);

        // 1) store 0xDEADBEEF @1024
        access("t1_store", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 18'd0, 1'b0);
        idle("t1_idle", 1, 32'd0);
        chk("t1:mem0", 32'(sram[0]), 32'h0000BEEF);
        chk("t1:mem1", 32'(sram[1]), 32'h0000DEAD);

        // 2) load @1024
        access("t2_load", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 18'd0, 1'b0);
        idle("t2_idle", 2, 32'hDEADBEEF);

        // 3) store 0x12345678 @1028, inputs scrambled mid-access
        access("t3_store", 1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'd2, 1'b1);
        idle("t3_idle", 1, 32'hDEADBEEF);
        chk("t3:mem2", 32'(sram[2]), 32'h00005678);
        chk("t3:mem3", 32'(sram[3]), 32'h00001234);

        // 4) ten idle cycles
        idle("t4_idle", 10, 32'hDEADBEEF);

        // 5) back-to-back loads
        access("t5_ld0", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 18'd0, 1'b0);
        access("t5_ld1", 1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678, 18'd2, 1'b0);
        idle("t5_idle", 1, 32'h12345678);

        // 6) reset in the middle of a store
        access("t6_pre", 1'b1, 1'b0, 32'd1032, 32'h11112222, 32'h12345678, 18'd4, 1'b0);
        idle("t6_pre_idle", 1, 32'h12345678);
        @(posedge clk);
        #2;
        bus.wr_en   = 1'b1;
        bus.address = 32'd1032;
        bus.wdata   = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        chk("t6:ce_n", 32'(SRAM_CE_N), 32'd1);
        chk("t6:we_n", 32'(SRAM_WE_N), 32'd1);
        chk("t6:oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("t6:rdata", bus.rdata, 32'd0);
        chk("t6:ready", 32'(bus.ready), 32'd1);
        chk("t6:mem4", 32'(sram[4]), 32'h0000F00D);
        chk("t6:mem5", 32'(sram[5]), 32'h00001111);
        idle("t6_idle", 2, 32'd0);

        // rd_en + wr_en together: write is performed
        access("t6_rdwr", 1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 32'd0, 18'd6, 1'b0);
        idle("t6_rdwr_idle", 1, 32'd0);
        chk("t6:mem6", 32'(sram[6]), 32'h00005A5A);
        chk("t6:mem7", 32'(sram[7]), 32'h0000A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
